// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared types and helpers for the adder self-test driver.
//   state_t       - sweep FSM states
//   A_LSB / b_lsb - operand field offsets on the 8-bit ui_in bus
//   expected_sum  - golden result for one operand pair
package adder_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned BUS_W = 8;
  localparam int unsigned A_LSB = 0;

  // Operand b sits directly above operand a on the bus.
  function automatic int unsigned b_lsb(input int unsigned width);
    return A_LSB + width;
  endfunction

  // Both operands arrive zero-extended; with 2*WIDTH <= 8 the WIDTH+1 bit
  // sum always fits, so the upper bits of the 8-bit result stay zero.
  function automatic logic [BUS_W-1:0] expected_sum(input logic [BUS_W-1:0] a,
                                                    input logic [BUS_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/adder_bist_vecgen.sv
// adder_bist_vecgen: exhaustive operand-pair counter.
//   clk, rst - clock, synchronous active-high reset
//   clr      - restart the sweep at vector 0
//   inc      - advance to the next vector
//   vec      - current vector {b, a}
//   last     - current vector is the final one (all ones)
module adder_bist_vecgen #(
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [VW-1:0] vec,
  output logic          last
);

  logic [VW-1:0] vec_r;

  // Vector counter: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r <= {VW{1'b0}};
    end else if (clr) begin
      vec_r <= {VW{1'b0}};
    end else if (inc) begin
      vec_r <= vec_r + VW'(1);
    end else begin
      vec_r <= vec_r;
    end
  end

  assign vec  = vec_r;
  assign last = (vec_r == {VW{1'b1}});

endmodule

// File: rtl/adder_bist.sv
// adder_bist: self-test initiator for the 8-bit-IO adder.
// Sweeps every (a, b) pair, compares uo_out to the golden sum, and reports.
//   clk, rst      - clock, synchronous active-high reset
//   start         - single-cycle sweep request (honoured in IDLE/DONE only)
//   dut_uo_out    - adder result bus
//   dut_ui_in     - registered operand bus {pad, b, a}
//   dut_ena       - adder enable, mirrors busy
//   busy, done    - sweep running / finished (done is sticky)
//   pass          - done with zero errors
//   err_count     - mismatching vectors, saturating at 255
//   fail_valid, fail_vec, fail_got - first failure capture
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dut_uo_out,
  output logic [7:0] dut_ui_in,
  output logic       dut_ena,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [7:0] fail_vec,
  output logic [7:0] fail_got
);

  localparam int unsigned VW          = 2 * WIDTH;
  localparam int unsigned B_LSB       = b_lsb(WIDTH);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_t        state_r, state_s;
  logic [VW-1:0] vec_s;
  logic          vec_last_s, vec_clr_s, vec_inc_s;
  logic          load_s, check_s, mismatch_s;
  logic [15:0]   settle_cnt_r;
  logic [7:0]    dut_ui_in_r, err_count_r, err_next_s;
  logic [7:0]    fail_vec_r, fail_got_r;
  logic [7:0]    op_a_s, op_b_s, exp_s;
  logic          busy_r, done_r, pass_r, fail_valid_r;

  adder_bist_vecgen #(.VW(VW)) u_vecgen (
    .clk  (clk),
    .rst  (rst),
    .clr  (vec_clr_s),
    .inc  (vec_inc_s),
    .vec  (vec_s),
    .last (vec_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_s   = state_r;
    vec_clr_s = 1'b0;
    vec_inc_s = 1'b0;
    load_s    = 1'b0;
    check_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_clr_s = 1'b1;
          state_s   = ST_DRIVE;
        end else begin
          state_s = state_r;
        end
      end
      ST_DRIVE: begin
        load_s  = 1'b1;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        check_s = 1'b1;
        if (vec_last_s) begin
          state_s = ST_DONE;
        end else begin
          vec_inc_s = 1'b1;
          state_s   = ST_DRIVE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scoreboard: golden compare on the vector currently on the bus.
  always_comb begin
    op_a_s     = 8'(dut_ui_in_r[A_LSB +: WIDTH]);
    op_b_s     = 8'(dut_ui_in_r[B_LSB +: WIDTH]);
    exp_s      = expected_sum(op_a_s, op_b_s);
    mismatch_s = check_s && (dut_uo_out != exp_s);
    if (vec_clr_s) begin
      err_next_s = 8'd0;
    end else if (mismatch_s && (err_count_r != 8'hFF)) begin
      err_next_s = err_count_r + 8'd1;
    end else begin
      err_next_s = err_count_r;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= 16'd0;
      dut_ui_in_r  <= 8'd0;
      err_count_r  <= 8'd0;
      fail_valid_r <= 1'b0;
      fail_vec_r   <= 8'd0;
      fail_got_r   <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      settle_cnt_r <= (state_r == ST_WAIT) ? (settle_cnt_r + 16'd1) : 16'd0;
      if (load_s) begin
        dut_ui_in_r <= 8'(vec_s);
      end
      err_count_r <= err_next_s;
      if (vec_clr_s) begin
        fail_valid_r <= 1'b0;
        fail_vec_r   <= 8'd0;
        fail_got_r   <= 8'd0;
      end else if (mismatch_s && !fail_valid_r) begin
        fail_valid_r <= 1'b1;
        fail_vec_r   <= dut_ui_in_r;
        fail_got_r   <= dut_uo_out;
      end
      busy_r <= (state_s == ST_DRIVE) || (state_s == ST_WAIT) || (state_s == ST_CHECK);
      done_r <= (state_s == ST_DONE);
      // Uses the post-update error count so pass is valid on the same edge as done.
      pass_r <= (state_s == ST_DONE) && (err_next_s == 8'd0);
    end
  end

  assign dut_ui_in  = dut_ui_in_r;
  assign dut_ena    = busy_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_count_r;
  assign fail_valid = fail_valid_r;
  assign fail_vec   = fail_vec_r;
  assign fail_got   = fail_got_r;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed bench for adder_bist with behavioural adder models.
// Instance a: SETTLE=1, model selectable (golden, bit0 stuck-0, bit7 stuck-1,
// 3-cycle latency). Instance b: SETTLE=3 driving a 3-cycle-latency adder.
module tb_adder_bist;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [1:0] mode_a;
  logic       sel;

  logic [7:0] uo_a, ui_a, err_a, fvec_a, fgot_a;
  logic       ena_a, busy_a, done_a, pass_a, fv_a;
  logic [7:0] uo_b, ui_b, err_b, fvec_b, fgot_b;
  logic       ena_b, busy_b, done_b, pass_b, fv_b;

  logic [7:0] pa0, pa1, pa2, pb0, pb1, pb2;

  logic [7:0] ui_x, err_x, fvec_x, fgot_x;
  logic       ena_x, busy_x, done_x, pass_x, fv_x;

  int n_vec;
  int n_err;
  int cyc;

  adder_bist #(.WIDTH(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_uo_out(uo_a),
    .dut_ui_in(ui_a), .dut_ena(ena_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
    .fail_vec(fvec_a), .fail_got(fgot_a)
  );

  adder_bist #(.WIDTH(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_uo_out(uo_b),
    .dut_ui_in(ui_b), .dut_ena(ena_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
    .fail_vec(fvec_b), .fail_got(fgot_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gold(input logic [7:0] ui);
    return {4'h0, ui[3:0]} + {4'h0, ui[7:4]};
  endfunction

  always_comb begin
    case (mode_a)
      2'd0:    uo_a = gold(ui_a);
      2'd1:    uo_a = gold(ui_a) & 8'hFE;
      2'd2:    uo_a = gold(ui_a) | 8'h80;
      default: uo_a = pa2;
    endcase
  end
  assign uo_b = pb2;

  always @(posedge clk) begin
    pa0 <= gold(ui_a); pa1 <= pa0; pa2 <= pa1;
    pb0 <= gold(ui_b); pb1 <= pb0; pb2 <= pb1;
  end

  assign ui_x   = sel ? ui_b   : ui_a;
  assign err_x  = sel ? err_b  : err_a;
  assign fvec_x = sel ? fvec_b : fvec_a;
  assign fgot_x = sel ? fgot_b : fgot_a;
  assign ena_x  = sel ? ena_b  : ena_a;
  assign busy_x = sel ? busy_b : busy_a;
  assign done_x = sel ? done_b : done_a;
  assign pass_x = sel ? pass_b : pass_a;
  assign fv_x   = sel ? fv_b   : fv_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(busy_x), 32'd0);
    check({tag, "_ena"},   32'(ena_x),  32'd0);
    check({tag, "_done"},  32'(done_x), 32'd0);
    check({tag, "_pass"},  32'(pass_x), 32'd0);
    check({tag, "_err"},   32'(err_x),  32'd0);
    check({tag, "_fv"},    32'(fv_x),   32'd0);
    check({tag, "_fvec"},  32'(fvec_x), 32'd0);
    check({tag, "_fgot"},  32'(fgot_x), 32'd0);
    check({tag, "_ui"},    32'(ui_x),   32'd0);
  endtask

  // Pulse start on the selected instance, then count edges until done (bounded).
  task automatic sweep(input logic which, input int restart_at, output int n);
    sel = which;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_rise", 32'(busy_x), 32'd1);
    check("done_clear", 32'(done_x), 32'd0);
    n = 0;
    while (done_x !== 1'b1 && n < 4000) begin
      if (n == restart_at) begin
        if (which) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      n++;
    end
    check("done_rise", 32'(done_x), 32'd1);
    check("busy_fall", 32'(busy_x), 32'd0);
    check("ena_fall",  32'(ena_x),  32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 2'd0;
    sel     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on both instances.
    sel = 1'b0; check_reset("rst_a");
    sel = 1'b1; check_reset("rst_b");

    // Golden adder: full clean sweep.
    mode_a = 2'd0;
    sweep(1'b0, -1, cyc);
    check("gold_cycles", 32'(cyc), 32'd768);
    check("gold_pass", 32'(pass_x), 32'd1);
    check("gold_err", 32'(err_x), 32'd0);
    check("gold_fv", 32'(fv_x), 32'd0);
    check("gold_last_ui", 32'(ui_x), 32'hFF);
    repeat (5) @(negedge clk);
    check("done_sticky", 32'(done_x), 32'd1);
    check("pass_sticky", 32'(pass_x), 32'd1);

    // Second start mid-sweep is ignored.
    sweep(1'b0, 100, cyc);
    check("restart_cycles", 32'(cyc), 32'd768);
    check("restart_pass", 32'(pass_x), 32'd1);
    check("restart_err", 32'(err_x), 32'd0);

    // Bit 0 stuck at 0: every odd sum fails (128 of 256).
    mode_a = 2'd1;
    sweep(1'b0, -1, cyc);
    check("s0_cycles", 32'(cyc), 32'd768);
    check("s0_err", 32'(err_x), 32'd128);
    check("s0_fv", 32'(fv_x), 32'd1);
    check("s0_fvec", 32'(fvec_x), 32'h01);
    check("s0_fgot", 32'(fgot_x), 32'h00);
    check("s0_pass", 32'(pass_x), 32'd0);

    // Bit 7 stuck at 1: all 256 fail, count saturates.
    mode_a = 2'd2;
    sweep(1'b0, -1, cyc);
    check("s7_err", 32'(err_x), 32'd255);
    check("s7_fvec", 32'(fvec_x), 32'h00);
    check("s7_fgot", 32'(fgot_x), 32'h80);
    check("s7_pass", 32'(pass_x), 32'd0);

    // 3-cycle-latency adder with too short a settle time.
    mode_a = 2'd3;
    sweep(1'b0, -1, cyc);
    check("lat_s1_cycles", 32'(cyc), 32'd768);
    check("lat_s1_pass", 32'(pass_x), 32'd0);

    // Same latency with SETTLE=3: clean, 256*5 cycles.
    sweep(1'b1, -1, cyc);
    check("lat_s3_cycles", 32'(cyc), 32'd1280);
    check("lat_s3_pass", 32'(pass_x), 32'd1);
    check("lat_s3_err", 32'(err_x), 32'd0);
    check("lat_s3_last_ui", 32'(ui_x), 32'hFF);

    // Reset mid-sweep, together with start: reset wins.
    mode_a = 2'd2;
    sel = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_busy", 32'(busy_x), 32'd1);
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    check_reset("midrst");
    @(negedge clk);
    check("rst_beats_start", 32'(busy_x), 32'd0);

    // Restart after reset runs a full sweep from vector 0.
    mode_a = 2'd1;
    sweep(1'b0, -1, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd768);
    check("post_rst_err", 32'(err_x), 32'd128);
    check("post_rst_fvec", 32'(fvec_x), 32'h01);
    check("post_rst_fgot", 32'(fgot_x), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
# adder_bist

Self-test driver for the Tiny Tapeout 8-bit-IO adder project: it is the initiator that drives `ui_in`/`ena` into the adder and checks `uo_out`. It sweeps every operand pair exhaustively, compares each result against an internal golden sum, and reports a pass/fail summary. It sits next to the adder in the harness or FPGA bring-up top and replaces manual host stimulus.

## Interface
- `WIDTH`, 4: operand width; a = `ui_in[WIDTH-1:0]`, b = `ui_in[2*WIDTH-1:WIDTH]`; requires 2*WIDTH ≤ 8.
- `SETTLE`, 1: wait cycles between driving a vector and sampling the result; must be ≥ 1.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `start`  in  1  single-cycle request to run a sweep.
- `dut_uo_out`  in  8  adder result bus.
- `dut_ui_in`  out  8  registered operand bus to the adder.
- `dut_ena`  out  1  adder enable; equals `busy`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; sticky until next accepted `start` or reset.
- `pass`  out  1  valid while `done`; 1 iff `err_count` = 0.
- `err_count`  out  8  mismatching vectors, saturating at 255.
- `fail_valid`  out  1  first failure captured.
- `fail_vec`  out  8  `dut_ui_in` value of first failing vector.
- `fail_got`  out  8  `dut_uo_out` sampled at first failure.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE/DONE: `start`=1 → clear vector counter, `err_count`, `fail_*`, `done`; go to DRIVE. `start` in DRIVE/WAIT/CHECK ignored.
- DRIVE: `dut_ui_in` ← {zero-pad, b, a} from vector counter v (a = v[WIDTH-1:0], b = v[2*WIDTH-1:WIDTH]); → WAIT.
- WAIT: count SETTLE cycles, then → CHECK.
- CHECK: expected = zero-extended (a + b), WIDTH+1 bits, upper bits 0. Mismatch if any of 8 bits of `dut_uo_out` differ. On mismatch: `err_count`++ (saturate 255); if `fail_valid`=0, capture `fail_vec`, `fail_got`, set `fail_valid`. Then v = 2^(2*WIDTH)-1 → DONE, else v++ → DRIVE.
- DONE: `done`=1, `busy`=0, `dut_ui_in` holds last vector.
- Reset values: state IDLE, `dut_ui_in`=0, `dut_ena`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=0, `fail_got`=0.
- `rst` mid-sweep: all of the above at next edge; no partial-result retention. `rst` and `start` together: reset wins.

## Timing
- Edge sampling `start`=1 → `busy`=1 from next cycle.
- Per vector: SETTLE+2 cycles (DRIVE 1, WAIT SETTLE, CHECK 1).
- `done` rises exactly 2^(2*WIDTH)·(SETTLE+2) cycles after `busy` rises; `busy` falls same edge.
- `dut_uo_out` sampled only in CHECK; value seen SETTLE+1 edges after `dut_ui_in` updated.
- `pass` = `done` & (`err_count`==0), registered with `done`.

## Structure
- `adder_bist_pkg`: state enum, `expected_sum(a,b)` function, operand field offsets as localparams derived from WIDTH.
- Sub-module `adder_bist_vecgen`: 2*WIDTH-bit vector counter with clear, increment, and `last` flag. FSM, settle counter, and scoreboard stay in `adder_bist`.

## Test plan
- Golden adder model, SETTLE=1, WIDTH=4, pulse `start` → `done` after 768 cycles, `pass`=1, `err_count`=0, `fail_valid`=0.
- Model with `uo_out[0]` stuck at 0 → `err_count`=128, `fail_vec`=0x01, `fail_got`=0x00, `pass`=0.
- Model with `uo_out[7]` stuck at 1 → all 256 mismatch, `err_count`=255 (saturated), `fail_vec`=0x00, `fail_got`=0x80.
- SETTLE=3, model with 3-cycle latency → `pass`=1 after 1280 cycles; same model with SETTLE=1 → `pass`=0.
- Pulse `start` again at cycle 100 of a sweep → ignored; `done` still at cycle 768, results unchanged.
- Assert `rst` at cycle 300 → next cycle all outputs at reset values; a new `start` restarts from vector 0x00 and completes normally.
